// File: rtl/toggle_pkg.sv
// Shared constants for the toggle-event decoder: FSM states and synchronizer depth.
// No logic and no latency of its own.
// No backpressure; it holds type and constant definitions only.
package toggle_pkg;

    // Prime first so the reference level is loaded before any edge can count as an event.
    typedef enum logic {
        S_PRIME = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    // Number of flops in the optional input synchronizer.
    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/tog_sync.sv
// Multi-flop synchronizer for the asynchronous toggle line; it resets to 0.
// Latency is SYNC_STAGES clock edges from din to dout.
// No backpressure; it samples on every edge.
module tog_sync
    import toggle_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [SYNC_STAGES-1:0] sync_ff;

    // Shift the line through the synchronizer chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], din};
        end
    end

    assign dout = sync_ff[SYNC_STAGES-1];

endmodule

// File: rtl/toggle_event_decoder.sv
// Converts each transition on a toggle-encoded line into a one-cycle pulse and a queued event.
// Latency: evt_pulse and pending update 1 edge after smp captures the line (3 edges with TOGGLE_DEC_SYNC_EN).
// Backpressure: the pending counter saturates, drops excess events and sets the sticky overflow flag.
module toggle_event_decoder
    import toggle_pkg::*;
#(
    parameter int CNT_W   = 4,
    parameter int TOTAL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tog_in,
    input  logic               evt_ready,
    input  logic               ovf_clr,
    output logic               evt_pulse,
    output logic               evt_valid,
    output logic [CNT_W-1:0]   pending,
    output logic [TOTAL_W-1:0] total,
    output logic               level,
    output logic               overflow
);

    localparam logic [CNT_W-1:0] PEND_MAX = '1;

    // smp_d is the value that smp captures on the next edge.
    logic smp_d;

`ifdef TOGGLE_DEC_SYNC_EN
    // The line comes from another clock domain, so the prime phase must cover the synchronizer and smp.
    localparam int PRIME_EDGES = SYNC_STAGES + 1;

    tog_sync u_tog_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (tog_in),
        .dout (smp_d)
    );
`else
    // The line is driven from this clock domain.
    localparam int PRIME_EDGES = 1;

    assign smp_d = tog_in;
`endif

    localparam logic [1:0] PRIME_LAST = 2'(PRIME_EDGES - 1);

    state_t     state;
    logic [1:0] prime_cnt;
    logic       smp;
    logic       ref_lvl;
    logic       det;
    logic       consume;
    logic       ovf_set;

    assign det       = (state == S_RUN) && (smp ^ ref_lvl);
    assign evt_valid = (pending != '0);
    assign consume   = evt_valid & evt_ready;
    assign ovf_set   = det & ~consume & (pending == PEND_MAX);
    assign level     = ref_lvl;

    // Sample register that feeds the transition detector.
    always_ff @(posedge clk) begin
        if (rst) begin
            smp <= 1'b0;
        end else begin
            smp <= smp_d;
        end
    end

    // Prime/run FSM.
    // On the last prime edge, ref_lvl takes the value smp is capturing on that same edge.
    // This means a line idling high out of reset does not produce an event.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_PRIME;
            prime_cnt <= 2'd0;
            ref_lvl   <= 1'b0;
            evt_pulse <= 1'b0;
            total     <= '0;
        end else if (state == S_PRIME) begin
            evt_pulse <= 1'b0;
            if (prime_cnt == PRIME_LAST) begin
                ref_lvl <= smp_d;
                state   <= S_RUN;
            end else begin
                prime_cnt <= prime_cnt + 2'd1;
            end
        end else begin
            evt_pulse <= det;
            if (det) begin
                ref_lvl <= smp;
                total   <= total + 1'b1;
            end
        end
    end

    // Saturating pending queue with a sticky overflow flag; when set and clear coincide, set wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            if (det && !consume) begin
                if (pending != PEND_MAX) begin
                    pending <= pending + 1'b1;
                end
            end else if (consume && !det) begin
                pending <= pending - 1'b1;
            end

            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_toggle_event_decoder.sv
// Directed test of toggle_event_decoder: the default instance plus a CNT_W=2 instance for saturation.
// Inputs are driven 1 time unit after posedge, and outputs are checked 1 time unit after posedge.
// The expected latency follows TOGGLE_DEC_SYNC_EN.
module tb_toggle_event_decoder;

`ifdef TOGGLE_DEC_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tog = 1'b1;
    logic       rdy = 1'b0;
    logic       clr = 1'b0;
    logic       pulse, valid, level, ovf;
    logic [3:0] pend;
    logic [7:0] tot;

    logic       tog2 = 1'b0;
    logic       rdy2 = 1'b0;
    logic       clr2 = 1'b0;
    logic       pulse2, valid2, level2, ovf2;
    logic [1:0] pend2;
    logic [7:0] tot2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    toggle_event_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .tog_in    (tog),
        .evt_ready (rdy),
        .ovf_clr   (clr),
        .evt_pulse (pulse),
        .evt_valid (valid),
        .pending   (pend),
        .total     (tot),
        .level     (level),
        .overflow  (ovf)
    );

    toggle_event_decoder #(.CNT_W(2), .TOTAL_W(8)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .tog_in    (tog2),
        .evt_ready (rdy2),
        .ovf_clr   (clr2),
        .evt_pulse (pulse2),
        .evt_valid (valid2),
        .pending   (pend2),
        .total     (tot2),
        .level     (level2),
        .overflow  (ovf2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Toggle the main line once and confirm a single pulse appears exactly LAT+1 edges later.
    task automatic toggle_once(input string tag);
        tog = ~tog;
        for (int i = 0; i < LAT; i++) begin
            tick();
            check({tag, "_early"}, {31'd0, pulse}, 32'd0);
        end
        tick();
        check({tag, "_pulse"}, {31'd0, pulse}, 32'd1);
        tick();
        check({tag, "_width"}, {31'd0, pulse}, 32'd0);
    endtask

    initial begin
        // Test 1: the line is held high through reset, with no spurious event after prime.
        tick();
        tick();
        check("rst_pulse",   {31'd0, pulse}, 32'd0);
        check("rst_pending", {28'd0, pend},  32'd0);
        check("rst_total",   {24'd0, tot},   32'd0);
        check("rst_level",   {31'd0, level}, 32'd0);
        check("rst_ovf",     {31'd0, ovf},   32'd0);
        check("rst_valid",   {31'd0, valid}, 32'd0);
        rst = 1'b0;
        repeat (LAT) tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_hi_pulse", {31'd0, pulse}, 32'd0);
        end
        check("idle_hi_level",   {31'd0, level}, 32'd1);
        check("idle_hi_pending", {28'd0, pend},  32'd0);

        // Test 2: three toggles with the consumer stalled.
        toggle_once("t2a");
        toggle_once("t2b");
        toggle_once("t2c");
        check("t2_pending", {28'd0, pend},  32'd3);
        check("t2_total",   {24'd0, tot},   32'd3);
        check("t2_valid",   {31'd0, valid}, 32'd1);
        check("t2_level",   {31'd0, level}, 32'd0);

        // Test 3: consume one event, then detect and consume in the same cycle.
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        check("t3_pend2", {28'd0, pend}, 32'd2);
        tog = ~tog;
        repeat (LAT) tick();
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        check("t3_pulse",   {31'd0, pulse}, 32'd1);
        check("t3_pending", {28'd0, pend},  32'd2);
        check("t3_total",   {24'd0, tot},   32'd4);

        // Drain the queue and keep evt_ready high at empty: the counter must not underflow.
        rdy = 1'b1;
        tick();
        tick();
        tick();
        tick();
        rdy = 1'b0;
        check("drain_pending", {28'd0, pend},  32'd0);
        check("drain_valid",   {31'd0, valid}, 32'd0);

        // Back-to-back toggles on three consecutive edges.
        for (int i = 1; i <= LAT + 4; i++) begin
            if (i <= 3) tog = ~tog;
            tick();
            check("b2b_pulse", {31'd0, pulse}, (i >= LAT + 1 && i <= LAT + 3) ? 32'd1 : 32'd0);
        end
        check("b2b_pending", {28'd0, pend},  32'd3);
        check("b2b_total",   {24'd0, tot},   32'd7);
        check("b2b_level",   {31'd0, level}, 32'd0);
        check("b2b_ovf",     {31'd0, ovf},   32'd0);

        // Test 4: saturation on the 2-bit instance.
        for (int i = 0; i < 5; i++) begin
            tog2 = ~tog2;
            tick();
        end
        repeat (LAT + 1) tick();
        check("sat_pending", {30'd0, pend2},  32'd3);
        check("sat_ovf",     {31'd0, ovf2},   32'd1);
        check("sat_total",   {24'd0, tot2},   32'd5);
        check("sat_valid",   {31'd0, valid2}, 32'd1);

        // A clear in the same cycle as a new overflow: set wins.
        tog2 = ~tog2;
        repeat (LAT) tick();
        clr2 = 1'b1;
        tick();
        clr2 = 1'b0;
        check("setwin_ovf",     {31'd0, ovf2},  32'd1);
        check("setwin_total",   {24'd0, tot2},  32'd6);
        check("setwin_pending", {30'd0, pend2}, 32'd3);
        clr2 = 1'b1;
        tick();
        clr2 = 1'b0;
        check("clr_ovf", {31'd0, ovf2}, 32'd0);

        // Test 5: reset mid-stream with three events queued.
        rst = 1'b1;
        tick();
        check("mrst_pulse",   {31'd0, pulse}, 32'd0);
        check("mrst_pending", {28'd0, pend},  32'd0);
        check("mrst_total",   {24'd0, tot},   32'd0);
        check("mrst_level",   {31'd0, level}, 32'd0);
        check("mrst_ovf",     {31'd0, ovf},   32'd0);
        check("mrst_valid",   {31'd0, valid}, 32'd0);
        rst = 1'b0;
        repeat (LAT) tick();
        toggle_once("t5");
        check("t5_pending", {28'd0, pend},  32'd1);
        check("t5_total",   {24'd0, tot},   32'd1);
        check("t5_level",   {31'd0, level}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
